// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// operand-timing encodings, mult/div latency defaults and the MD FSM states.
package pipe_hazard_ctrl_pkg;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;
  typedef logic [4:0] reg_idx_t;

  localparam tuse_t TUSE_NONE = 2'd3;
  localparam tnew_t TNEW_NONE = 2'd0;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned MD_CNT_W     = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source operand hazards when a younger-needed value is still being produced
  // in E or M; register 0 is hard-wired and never waits.
  function automatic logic src_hazard(input reg_idx_t src, input tuse_t tuse,
                                      input reg_idx_t rd_e, input tnew_t tnew_e,
                                      input reg_idx_t rd_m, input tnew_t tnew_m);
    logic hit_e;
    logic hit_m;
    hit_e = (src == rd_e) && (tuse < tnew_e);
    hit_m = (src == rd_m) && (tuse < tnew_m);
    return (src != '0) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle: D/E/M hazard inputs toward the controller and the
// stall/enable outputs back to the pipeline registers.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  reg_idx_t    rsD;
  reg_idx_t    rtD;
  tuse_t       tuse_rsD;
  tuse_t       tuse_rtD;
  reg_idx_t    rd_rsE;
  tnew_t       tnewE;
  reg_idx_t    rd_rsM;
  tnew_t       tnewM;
  logic        md_startE;
  logic        md_divE;
  logic        md_useD;
  logic        enPC;
  logic        enD;
  logic        clrE;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output rsD, rtD, tuse_rsD, tuse_rtD, rd_rsE, tnewE, rd_rsM, tnewM,
    output md_startE, md_divE, md_useD,
    input  enPC, enD, clrE, md_busy, stall_cnt
  );

  modport slave (
    input  rsD, rtD, tuse_rsD, tuse_rtD, rd_rsE, tnewE, rd_rsM, tnewM,
    input  md_startE, md_divE, md_useD,
    output enPC, enD, clrE, md_busy, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Mult/div occupancy timer: holds busy for exactly MULT_CYC or DIV_CYC cycles
// after an issue, ignoring further issues until it returns idle.
module md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYC);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYC);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // md_cnt holds the remaining busy cycles including the current one.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d  = MD_BUSY;
          md_cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        md_cnt_d = md_cnt_q - 1'b1;
        if (md_cnt_q == MD_CNT_W'(1)) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d  = MD_IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: combinational data/HI-LO stall detection driving
// PC/IF-ID enables and ID/EX bubble insertion, plus a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input logic             clk,
  input logic             reset,
  pipe_hazard_ctrl_if.slave hz
);

  logic        md_busy;
  logic        data_stall;
  logic        md_stall;
  logic        stall;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  md_busy_timer #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_md_busy_timer (
    .clk   (clk),
    .reset (reset),
    .start (hz.md_startE),
    .is_div(hz.md_divE),
    .busy  (md_busy)
  );

  // The registered busy flag is masked during reset so the enables reflect
  // the unit being flushed in that same cycle.
  always_comb begin
    data_stall = src_hazard(hz.rsD, hz.tuse_rsD, hz.rd_rsE, hz.tnewE, hz.rd_rsM, hz.tnewM) ||
                 src_hazard(hz.rtD, hz.tuse_rtD, hz.rd_rsE, hz.tnewE, hz.rd_rsM, hz.tnewM);
    md_stall   = hz.md_useD && ((md_busy && !reset) || hz.md_startE);
    stall      = data_stall || md_stall;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.enPC      = !stall;
  assign hz.enD       = !stall;
  assign hz.clrE      = stall;
  assign hz.md_busy   = md_busy;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, multiply busy cycles after issue.
REQ-002 Parameter DIV_CYC, default 10, divide busy cycles after issue.
REQ-003 clk  in  1  single system clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rsD, rtD  in  5 each  source register numbers of the D-stage instruction.
REQ-006 tuse_rsD, tuse_rtD  in  2 each  cycles until D instruction needs rs/rt (3 = not used).
REQ-007 rd_rsE  in  5  destination register of the E-stage instruction (0 = none).
REQ-008 tnewE  in  2  cycles until E-stage result is available.
REQ-009 rd_rsM  in  5  destination register of the M-stage instruction (0 = none).
REQ-010 tnewM  in  2  cycles until M-stage result is available.
REQ-011 md_startE  in  1  E-stage instruction issues a mult/div this cycle.
REQ-012 md_divE  in  1  1 = divide, 0 = multiply; qualified by md_startE.
REQ-013 md_useD  in  1  D-stage instruction reads or writes HI/LO or starts mult/div.
REQ-014 enPC  out  1  PC register write enable.
REQ-015 enD  out  1  IF/ID register write enable.
REQ-016 clrE  out  1  synchronous clear of ID/EX register (bubble insert).
REQ-017 md_busy  out  1  mult/div unit occupied.
REQ-018 stall_cnt  out  32  number of stall cycles since reset.

Function
REQ-019 Data stall SHALL assert when (rsD!=0 & rsD==rd_rsE & tuse_rsD<tnewE) or (rsD!=0 & rsD==rd_rsM & tuse_rsD<tnewM), and likewise for rtD/tuse_rtD.
REQ-020 Register 0 SHALL never cause a stall, regardless of rd_rsE/rd_rsM.
REQ-021 MD stall SHALL assert when md_useD & (md_busy | md_startE).
REQ-022 stall = data stall | MD stall; combinational, same cycle as inputs.
REQ-023 enPC = enD = ~stall; clrE = stall.
REQ-024 MD FSM states: IDLE, BUSY; 4-bit down-counter md_cnt.
REQ-025 IDLE->BUSY on md_startE; md_cnt loads DIV_CYC if md_divE else MULT_CYC.
REQ-026 In BUSY md_cnt decrements each cycle; BUSY->IDLE when md_cnt==1 (after exactly N busy cycles).
REQ-027 md_busy = (state==BUSY), registered; first high the cycle after md_startE.
REQ-028 md_startE while BUSY SHALL be ignored (no reload, no state change).
REQ-029 stall_cnt increments by 1 in each cycle where stall is high; saturates at 0xFFFFFFFF.
REQ-030 Data stall and MD stall in the same cycle count once in stall_cnt.

Reset
REQ-031 On reset: state=IDLE, md_cnt=0, md_busy=0, stall_cnt=0.
REQ-032 Reset during BUSY SHALL abort the operation; md_busy low the next cycle.
REQ-033 During reset cycle outputs enPC/enD/clrE still follow REQ-023 from current inputs with md_busy=0 term.

Structure
REQ-034 Shared package holds TUSE/TNEW encodings, TUSE_NONE=3, MULT_CYC/DIV_CYC defaults, FSM state encoding.
REQ-035 One sub-module md_busy_timer (FSM + counter, REQ-024..028); stall compare logic and stall_cnt stay in top.

Verification
REQ-036 rsD=5,tuse_rsD=0; rd_rsE=5,tnewE=2 -> enPC=0,enD=0,clrE=1; next cycle tnewM=1 rd_rsM=5 -> stall still 1; then clear -> enPC=1.
REQ-037 rsD=0,tuse_rsD=0; rd_rsE=0,tnewE=2 -> stall=0, stall_cnt unchanged.
REQ-038 md_startE=1,md_divE=0 one cycle -> md_busy high exactly 5 cycles; with md_useD=1 throughout, stall high 6 cycles (start cycle + 5), stall_cnt=6.
REQ-039 md_startE=1,md_divE=1 -> md_busy 10 cycles; second md_startE at busy cycle 3 -> still ends after 10 total.
REQ-040 Start divide, assert reset at busy cycle 4 -> md_busy=0 next cycle, stall_cnt=0.
REQ-041 Force stall_cnt near max (hold stall 2^32 cycles or backdoor-load 0xFFFFFFFE), hold stall 3 cycles -> stall_cnt=0xFFFFFFFF.
